// File: rtl/fetch_pair_queue_if.sv
// Fetch-to-memory and fetch-to-decode bundle for the pair queue.
// master = fetch stage side, slave = memory/decode side.
interface fetch_pair_queue_if #(
    parameter int AW = 8,
    parameter int IW = 32
) ();
    logic [AW-1:0] imem_addr0;
    logic [AW-1:0] imem_addr1;
    logic          imem_en;
    logic [IW-1:0] imem_rdata0;
    logic [IW-1:0] imem_rdata1;
    logic          dec_valid;
    logic          dec_ready;
    logic [IW-1:0] dec_instr0;
    logic [IW-1:0] dec_instr1;
    logic [AW-1:0] dec_pc;

    modport master (
        output imem_addr0, imem_addr1, imem_en,
        input  imem_rdata0, imem_rdata1,
        output dec_valid, dec_instr0, dec_instr1, dec_pc,
        input  dec_ready
    );

    modport slave (
        input  imem_addr0, imem_addr1, imem_en,
        output imem_rdata0, imem_rdata1,
        input  dec_valid, dec_instr0, dec_instr1, dec_pc,
        output dec_ready
    );
endinterface

// File: rtl/fetch_pair_queue.sv
// Dual-issue fetch stage: requests PC/PC+4 pairs and queues
// the returned pairs for decode, with stall and flush control.
module fetch_pair_queue #(
    parameter int DEPTH = 4,
    parameter int AW    = 8,
    parameter int IW    = 32
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [AW-1:0]          pc_in,
    input  logic                   flush,
    output logic                   stall_out,
    output logic [$clog2(DEPTH):0] occupancy,
    fetch_pair_queue_if.master     bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    typedef struct packed {
        logic [IW-1:0] instr0;
        logic [IW-1:0] instr1;
        logic [AW-1:0] pc;
    } entry_t;

    entry_t        fifo_q [DEPTH];
    entry_t        fifo_d [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          resp_valid_q, resp_valid_d;
    logic [AW-1:0] resp_pc_q, resp_pc_d;

    logic          not_empty;
    logic          req_fire;
    logic          push;
    logic          pop;
    logic [CW:0]   reserved;

    // Slot for the in-flight response is reserved up front,
    // so a push can never find the queue full.
    always_comb begin
        not_empty  = (count_q != '0);
        reserved   = {1'b0, count_q} + (CW+1)'(resp_valid_q);
        stall_out  = !flush && (reserved >= (CW+1)'(DEPTH));
        req_fire   = !stall_out && !flush;
        push       = resp_valid_q && !flush;
        pop        = not_empty && bus.dec_ready && !flush;

        bus.imem_en    = req_fire;
        bus.imem_addr0 = pc_in;
        bus.imem_addr1 = pc_in + AW'(4);
        bus.dec_valid  = not_empty;
        bus.dec_instr0 = fifo_q[rd_ptr_q].instr0;
        bus.dec_instr1 = fifo_q[rd_ptr_q].instr1;
        bus.dec_pc     = fifo_q[rd_ptr_q].pc;
        occupancy      = count_q;
    end

    always_comb begin
        fifo_d       = fifo_q;
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        count_d      = count_q;
        resp_valid_d = req_fire;
        resp_pc_d    = pc_in;

        if (push) begin
            fifo_d[wr_ptr_q] = '{
                instr0: bus.imem_rdata0,
                instr1: bus.imem_rdata1,
                pc:     resp_pc_q
            };
            wr_ptr_d = wr_ptr_q + PW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end

        unique case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase

        if (flush) begin
            wr_ptr_d     = '0;
            rd_ptr_d     = '0;
            count_d      = '0;
            resp_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                fifo_q[i] <= '0;
            end
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            resp_valid_q <= 1'b0;
            resp_pc_q    <= '0;
        end else begin
            fifo_q       <= fifo_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            resp_valid_q <= resp_valid_d;
            resp_pc_q    <= resp_pc_d;
        end
    end
endmodule

// File: tb/tb_fetch_pair_queue.sv
// Randomized bench for fetch_pair_queue against a queue-based
// reference of requests in flight and pairs awaiting decode.
module tb_fetch_pair_queue;
    localparam int DEPTH = 4;
    localparam int AW    = 8;
    localparam int IW    = 32;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [AW-1:0] pc_in = '0;
    logic          flush = 1'b0;
    logic          stall_out;
    logic [2:0]    occupancy;

    fetch_pair_queue_if #(.AW(AW), .IW(IW)) bus ();

    fetch_pair_queue #(.DEPTH(DEPTH), .AW(AW), .IW(IW)) dut (
        .clk       (clk),
        .reset     (reset),
        .pc_in     (pc_in),
        .flush     (flush),
        .stall_out (stall_out),
        .occupancy (occupancy),
        .bus       (bus.master)
    );

    always #5 clk = ~clk;

    // Synchronous memory: each word equals its byte address.
    initial begin
        bus.imem_rdata0 = '0;
        bus.imem_rdata1 = '0;
        bus.dec_ready   = 1'b0;
    end
    always @(posedge clk) begin
        if (bus.imem_en) begin
            bus.imem_rdata0 <= 32'(bus.imem_addr0);
            bus.imem_rdata1 <= 32'(bus.imem_addr1);
        end
    end

    int tests = 0;
    int fails = 0;

    logic [AW-1:0] pend_q[$];
    logic          infl_v  = 1'b0;
    logic [AW-1:0] infl_pc = '0;
    logic [AW-1:0] pc      = '0;

    task automatic check(input string tag,
                         input logic [31:0] obs,
                         input logic [31:0] exp);
        tests++;
        if (obs !== exp) begin
            fails++;
            $display("FAIL %s: got %0h want %0h @%0t",
                     tag, obs, exp, $time);
        end
    endtask

    task automatic clear_model();
        pend_q.delete();
        infl_v = 1'b0;
        pc     = '0;
    endtask

    task automatic step(input logic rdy, input logic fl,
                        input logic [AW-1:0] tgt,
                        input logic rst);
        logic e_stall;
        logic e_pop;
        logic [AW-1:0] hd;
        @(negedge clk);
        reset = rst;
        if (rst) clear_model();
        bus.dec_ready = rdy;
        flush = fl;
        pc_in = pc;
        #1;
        e_stall = !fl &&
                  (pend_q.size() + int'(infl_v) >= DEPTH);
        e_pop = (pend_q.size() != 0) && rdy;
        check("stall", 32'(stall_out), 32'(e_stall));
        check("en", 32'(bus.imem_en), 32'(!e_stall && !fl));
        check("addr0", 32'(bus.imem_addr0), 32'(pc));
        check("addr1", 32'(bus.imem_addr1), 32'(AW'(pc + 4)));
        check("occ", 32'(occupancy), 32'(pend_q.size()));
        check("valid", 32'(bus.dec_valid),
              32'(pend_q.size() != 0));
        if (pend_q.size() != 0) begin
            hd = pend_q[0];
            check("dpc", 32'(bus.dec_pc), 32'(hd));
            check("i0", bus.dec_instr0, 32'(hd));
            check("i1", bus.dec_instr1, 32'(AW'(hd + 4)));
        end
        @(posedge clk);
        if (rst) begin
            clear_model();
        end else if (fl) begin
            pend_q.delete();
            infl_v = 1'b0;
            pc     = tgt;
        end else begin
            if (e_pop) void'(pend_q.pop_front());
            if (infl_v) pend_q.push_back(infl_pc);
            infl_v  = !e_stall;
            infl_pc = pc;
            if (!e_stall) pc = pc + AW'(8);
        end
    endtask

    initial begin
        logic r;
        logic f;
        logic x;
        step(1'b1, 1'b0, '0, 1'b1);
        for (int i = 0; i < 4; i++) step(1'b1, 1'b0, '0, 1'b0);

        step(1'b0, 1'b0, '0, 1'b1);
        for (int i = 0; i < 8; i++) step(1'b0, 1'b0, '0, 1'b0);
        @(negedge clk);
        pc_in = pc;
        #1;
        check("full_occ", 32'(occupancy), 32'd4);
        check("full_stall", 32'(stall_out), 32'd1);
        check("hold_pc", 32'(bus.imem_addr0), 32'h20);
        check("full_head", 32'(bus.dec_pc), 32'h00);

        step(1'b0, 1'b1, 8'h40, 1'b0);
        for (int i = 0; i < 12; i++) step(1'b1, 1'b0, '0, 1'b0);

        step(1'b1, 1'b1, 8'hFC, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, '0, 1'b0);
        for (int i = 0; i < 4; i++) step(1'b1, 1'b0, '0, 1'b0);

        step(1'b0, 1'b1, 8'h80, 1'b0);
        for (int i = 0; i < 4; i++) step(1'b0, 1'b0, '0, 1'b0);
        step(1'b1, 1'b0, '0, 1'b1);
        for (int i = 0; i < 5; i++) step(1'b1, 1'b0, '0, 1'b0);

        for (int i = 0; i < 400; i++) begin
            r = ($urandom_range(0, 2) != 0);
            f = ($urandom_range(0, 9) == 0);
            x = ($urandom_range(0, 59) == 0);
            step(r, f, AW'($urandom) & 8'hFC, x);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
